fetch_pc_ctrl: RTL and testbench

FETCH_PC_CTRL -- requirements
Module: fetch_pc_ctrl

---
 rtl/ctrl_encode_def_pkg.sv | 25 ++
 rtl/fetch_pc_ctrl_buf.sv | 53 +++++
 rtl/fetch_pc_ctrl.sv | 139 +++++++++++++
 tb/tb_fetch_pc_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_encode_def_pkg.sv
// Shared control encodings: fetch FSM states, boot address, next-PC op codes.
package ctrl_encode_def_pkg;

    // First fetch address after reset unless overridden at the top level.
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_REQ  = 2'b01,
        ST_RESP = 2'b10
    } fetch_state_e;

    // Next-PC datapath operation codes (consumed by the next-PC datapath).
    localparam logic [1:0] NPC_PLUS4  = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;
    localparam logic [1:0] NPC_JALR   = 2'b11;

    // Instruction fetches are always word aligned; drop the byte offset.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_pc_ctrl_buf.sv
// One-entry IF/ID output buffer with valid/ready handshake and flush.
module fetch_buf (
    input  logic        clk,
    input  logic        rstn,
    input  logic        load_i,
    input  logic [31:0] load_pc_i,
    input  logic [31:0] load_instr_i,
    input  logic        flush_i,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o
);

    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;

    // Next contents: flush wins, then a new load (which may replace an entry
    // being consumed in the same cycle), then a plain consume.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            pc_d    = load_pc_i;
            instr_d = load_instr_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Buffer registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            valid_q <= 1'b0;
            pc_q    <= 32'h0;
            instr_q <= 32'h0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC sequencer: one outstanding instruction-memory request at a time,
// redirect handling with response kill, and a one-entry IF/ID buffer.
module fetch_pc_ctrl
    import ctrl_encode_def_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        redir_valid_i,
    input  logic [31:0] redir_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_instr_o,
    input  logic        if_ready_i,
    output logic        flush_o,
    output logic        misalign_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  addr_q, addr_d;
    logic [31:0]  pend_q, pend_d;
    logic         kill_q, kill_d;
    logic         buf_load;
    logic         gnt_fire;
    logic [31:0]  tgt_aligned;

    assign tgt_aligned = word_align(redir_target_i);
    assign gnt_fire    = imem_req_o & imem_gnt_i;
    assign imem_addr_o = addr_q;

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Address, kill flag and pending redirect target registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            addr_q <= RESET_PC;
            pend_q <= 32'h0;
            kill_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            pend_q <= pend_d;
            kill_q <= kill_d;
        end
    end

    // Next-state logic; a redirect always takes priority over grant/response.
    // While a request is outstanding the address register keeps the fetched
    // PC so the response can be tagged; the redirect target waits in pend_q.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        pend_d  = pend_q;
        kill_d  = kill_q;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_REQ;
                if (redir_valid_i) begin
                    addr_d = tgt_aligned;
                end
            end
            ST_REQ: begin
                if (redir_valid_i) begin
                    if (gnt_fire) begin
                        state_d = ST_RESP;
                        kill_d  = 1'b1;
                        pend_d  = tgt_aligned;
                    end else begin
                        addr_d = tgt_aligned;
                    end
                end else if (gnt_fire) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (redir_valid_i) begin
                    if (imem_rvalid_i) begin
                        state_d = ST_REQ;
                        kill_d  = 1'b0;
                        addr_d  = tgt_aligned;
                    end else begin
                        kill_d = 1'b1;
                        pend_d = tgt_aligned;
                    end
                end else if (imem_rvalid_i) begin
                    state_d = ST_REQ;
                    kill_d  = 1'b0;
                    addr_d  = kill_q ? pend_q : addr_q + 32'd4;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // Outputs: request only when the buffer has room (empty or draining this
    // cycle), which keeps a returning response from ever meeting a full buffer.
    always_comb begin
        imem_req_o = 1'b0;
        buf_load   = 1'b0;
        flush_o    = redir_valid_i;
        misalign_o = redir_valid_i & (|redir_target_i[1:0]);
        case (state_q)
            ST_REQ:  imem_req_o = ~if_valid_o | if_ready_i;
            ST_RESP: buf_load   = imem_rvalid_i & ~kill_q & ~redir_valid_i;
            default: begin
                imem_req_o = 1'b0;
                buf_load   = 1'b0;
            end
        endcase
    end

    fetch_buf u_buf (
        .clk          (clk),
        .rstn         (rstn),
        .load_i       (buf_load),
        .load_pc_i    (addr_q),
        .load_instr_i (imem_rdata_i),
        .flush_i      (redir_valid_i),
        .ready_i      (if_ready_i),
        .valid_o      (if_valid_o),
        .pc_o         (if_pc_o),
        .instr_o      (if_instr_o)
    );

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Self-checking bench for fetch_pc_ctrl: directed vector table, hand-written
// stall/reset sequences, then randomized traffic against a transaction model.
module tb_fetch_pc_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk;
    logic        rstn;
    logic        redir_valid_i;
    logic [31:0] redir_target_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_instr_o;
    logic        if_ready_i;
    logic        flush_o;
    logic        misalign_o;

    int errors = 0;
    int checks = 0;

    fetch_pc_ctrl #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .redir_valid_i  (redir_valid_i),
        .redir_target_i (redir_target_i),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_gnt_i     (imem_gnt_i),
        .imem_rvalid_i  (imem_rvalid_i),
        .imem_rdata_i   (imem_rdata_i),
        .if_valid_o     (if_valid_o),
        .if_pc_o        (if_pc_o),
        .if_instr_o     (if_instr_o),
        .if_ready_i     (if_ready_i),
        .flush_o        (flush_o),
        .misalign_o     (misalign_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        redir;
        logic [31:0] tgt;
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        ready;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_flush;
        logic        e_mis;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    vec_t vecs[$];

    // Transaction-level reference state.
    bit          m_boot;
    bit          m_outst;
    bit          m_drop;
    logic [31:0] m_next;
    logic [31:0] m_out_pc;
    ent_t        m_buf[$];
    // Memory responder state.
    bit          mem_busy;
    int          mem_wait;
    logic [31:0] mem_data;

    task automatic chk(input string tag, input string what,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h", tag, what, act, exp);
        end
    endtask

    task automatic drive(input logic redir, input logic [31:0] tgt, input logic gnt,
                         input logic rvalid, input logic [31:0] rdata, input logic ready);
        redir_valid_i  = redir;
        redir_target_i = tgt;
        imem_gnt_i     = gnt;
        imem_rvalid_i  = rvalid;
        imem_rdata_i   = rdata;
        if_ready_i     = ready;
    endtask

    task automatic expect_o(input string tag, input logic req, input logic [31:0] addr,
                            input logic valid, input logic [31:0] pc, input logic [31:0] instr,
                            input logic flush, input logic mis);
        chk(tag, "req", {31'b0, imem_req_o}, {31'b0, req});
        chk(tag, "addr", imem_addr_o, addr);
        chk(tag, "valid", {31'b0, if_valid_o}, {31'b0, valid});
        if (valid) begin
            chk(tag, "pc", if_pc_o, pc);
            chk(tag, "instr", if_instr_o, instr);
        end
        chk(tag, "flush", {31'b0, flush_o}, {31'b0, flush});
        chk(tag, "misalign", {31'b0, misalign_o}, {31'b0, mis});
    endtask

    // Apply reset for two edges, check the reset state, release at a negedge.
    task automatic do_reset();
        rstn = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        repeat (2) @(negedge clk);
        expect_o("reset", 1'b0, RST_PC, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("reset", "pc", if_pc_o, 32'h0);
        chk("reset", "instr", if_instr_o, 32'h0);
        rstn     = 1'b1;
        m_boot   = 1'b1;
        m_outst  = 1'b0;
        m_drop   = 1'b0;
        m_next   = RST_PC;
        m_out_pc = 32'h0;
        m_buf.delete();
        mem_busy = 1'b0;
        mem_wait = 0;
        mem_data = 32'h0;
        $display("reset applied and released");
    endtask

    task automatic add(input logic redir, input logic [31:0] tgt, input logic gnt,
                       input logic rvalid, input logic [31:0] rdata, input logic ready,
                       input logic e_req, input logic [31:0] e_addr, input logic e_valid,
                       input logic [31:0] e_pc, input logic [31:0] e_instr,
                       input logic e_flush, input logic e_mis);
        vecs.push_back('{redir, tgt, gnt, rvalid, rdata, ready,
                         e_req, e_addr, e_valid, e_pc, e_instr, e_flush, e_mis});
    endtask

    initial begin
        logic [31:0] tgt_al;
        logic        e_req;
        logic        granted;
        logic        consume;
        logic        r_redir, r_gnt, r_rvalid, r_ready;
        logic [31:0] r_tgt, r_rdata;
        int          err_before;

        //   redir tgt           gnt rv  rdata          rdy  req addr          vld pc            instr          fl mis
        add(0, 32'h0,         0, 0, 32'h0,         1,   0, 32'h0000_0000, 0, 32'h0,         32'h0,         0, 0); // BOOT
        add(0, 32'h0,         1, 0, 32'h0,         1,   1, 32'h0000_0000, 0, 32'h0,         32'h0,         0, 0); // first grant
        add(0, 32'h0,         0, 1, 32'h13,        1,   0, 32'h0000_0000, 0, 32'h0,         32'h0,         0, 0); // response
        add(0, 32'h0,         0, 0, 32'h0,         1,   1, 32'h0000_0004, 1, 32'h0,         32'h13,        0, 0); // buffered, next at 4
        add(0, 32'h0,         1, 0, 32'h0,         1,   1, 32'h0000_0004, 0, 32'h0,         32'h0,         0, 0); // grant at 4
        add(1, 32'h100,       0, 0, 32'h0,         1,   0, 32'h0000_0004, 0, 32'h0,         32'h0,         1, 0); // redirect in RESP
        add(0, 32'h0,         0, 1, 32'hDEAD_BEEF, 1,   0, 32'h0000_0004, 0, 32'h0,         32'h0,         0, 0); // killed response
        add(0, 32'h0,         0, 0, 32'h0,         1,   1, 32'h0000_0100, 0, 32'h0,         32'h0,         0, 0); // fetch at 0x100
        add(1, 32'h200,       1, 0, 32'h0,         1,   1, 32'h0000_0100, 0, 32'h0,         32'h0,         1, 0); // redirect with grant
        add(0, 32'h0,         0, 1, 32'h1111_1111, 1,   0, 32'h0000_0100, 0, 32'h0,         32'h0,         0, 0); // killed response
        add(0, 32'h0,         0, 0, 32'h0,         1,   1, 32'h0000_0200, 0, 32'h0,         32'h0,         0, 0); // fetch at 0x200
        add(1, 32'h102,       0, 0, 32'h0,         1,   1, 32'h0000_0200, 0, 32'h0,         32'h0,         1, 1); // misaligned target
        add(0, 32'h0,         0, 0, 32'h0,         1,   1, 32'h0000_0100, 0, 32'h0,         32'h0,         0, 0); // aligned to 0x100
        add(0, 32'h0,         1, 0, 32'h0,         1,   1, 32'h0000_0100, 0, 32'h0,         32'h0,         0, 0); // grant at 0x100
        add(0, 32'h0,         0, 1, 32'hABCD_0001, 1,   0, 32'h0000_0100, 0, 32'h0,         32'h0,         0, 0); // response
        add(0, 32'h0,         1, 0, 32'h0,         0,   0, 32'h0000_0104, 1, 32'h0000_0100, 32'hABCD_0001, 0, 0); // stall begins

        do_reset();

        for (int i = 0; i < vecs.size(); i++) begin
            err_before = errors;
            drive(vecs[i].redir, vecs[i].tgt, vecs[i].gnt, vecs[i].rvalid, vecs[i].rdata, vecs[i].ready);
            #1;
            expect_o($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid,
                     vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_flush, vecs[i].e_mis);
            $display("vec %0d: req=%0b addr=%h valid=%0b pc=%h new_errors=%0d",
                     i, imem_req_o, imem_addr_o, if_valid_o, if_pc_o, errors - err_before);
            @(negedge clk);
        end

        // Stall: buffer full, IF/ID not ready; memory would grant if asked.
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
            #1;
            expect_o($sformatf("stall%0d", i), 1'b0, 32'h104, 1'b1, 32'h100, 32'hABCD_0001, 1'b0, 1'b0);
            $display("stall cycle %0d: req=%0b pc=%h", i, imem_req_o, if_pc_o);
            @(negedge clk);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        #1;
        expect_o("resume", 1'b1, 32'h104, 1'b1, 32'h100, 32'hABCD_0001, 1'b0, 1'b0);
        $display("stall released: req=%0b addr=%h", imem_req_o, imem_addr_o);
        @(negedge clk);

        // Move to 0x40, take a grant, then reset while the response is pending.
        drive(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 1'b1);
        #1;
        expect_o("to40", 1'b1, 32'h104, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        #1;
        expect_o("gnt40", 1'b1, 32'h40, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rstn = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        #1;
        expect_o("resp40", 1'b0, 32'h40, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h5555_5555, 1'b1);
        #1;
        expect_o("postrst", 1'b0, RST_PC, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        #1;
        expect_o("postrst1", 1'b1, RST_PC, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        expect_o("postrst2", 1'b1, RST_PC, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        $display("mid-response reset: addr=%h valid=%0b", imem_addr_o, if_valid_o);
        @(negedge clk);

        // Randomized traffic against the transaction model.
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            r_redir  = ($urandom_range(0, 7) == 0);
            r_tgt    = $urandom();
            r_gnt    = ($urandom_range(0, 2) != 0);
            r_ready  = ($urandom_range(0, 3) != 0);
            r_rvalid = mem_busy && (mem_wait == 0);
            r_rdata  = r_rvalid ? mem_data : $urandom();
            drive(r_redir, r_tgt, r_gnt, r_rvalid, r_rdata, r_ready);
            tgt_al = {r_tgt[31:2], 2'b00};
            #1;
            e_req = !m_boot && !m_outst && (m_buf.size() == 0 || r_ready);
            chk("rnd", "req", {31'b0, imem_req_o}, {31'b0, e_req});
            if (!m_outst) chk("rnd", "addr", imem_addr_o, m_next);
            chk("rnd", "valid", {31'b0, if_valid_o}, {31'b0, m_buf.size() != 0});
            if (m_buf.size() != 0) begin
                chk("rnd", "pc", if_pc_o, m_buf[0].pc);
                chk("rnd", "instr", if_instr_o, m_buf[0].instr);
            end
            chk("rnd", "flush", {31'b0, flush_o}, {31'b0, r_redir});
            chk("rnd", "misalign", {31'b0, misalign_o}, {31'b0, r_redir && (r_tgt[1:0] != 2'b00)});
            if (if_valid_o && r_ready)
                $display("rnd %0d: consumed pc=%h instr=%h", cyc, if_pc_o, if_instr_o);
            @(posedge clk);
            granted = e_req && r_gnt;
            consume = (m_buf.size() != 0) && r_ready;
            if (r_redir) m_buf.delete();
            else if (consume) void'(m_buf.pop_front());
            if (m_boot) begin
                m_boot = 1'b0;
                if (r_redir) m_next = tgt_al;
            end else if (!m_outst) begin
                if (granted) begin
                    m_outst  = 1'b1;
                    m_out_pc = m_next;
                    m_drop   = r_redir;
                end
                if (r_redir) m_next = tgt_al;
            end else if (r_rvalid) begin
                m_outst = 1'b0;
                if (r_redir) begin
                    m_next = tgt_al;
                end else if (!m_drop) begin
                    m_buf.push_back('{m_out_pc, r_rdata});
                    m_next = m_out_pc + 32'd4;
                end
                m_drop = 1'b0;
            end else if (r_redir) begin
                m_drop = 1'b1;
                m_next = tgt_al;
            end
            if (r_rvalid) mem_busy = 1'b0;
            else if (mem_busy) mem_wait--;
            if (granted) begin
                mem_busy = 1'b1;
                mem_wait = $urandom_range(0, 2);
                mem_data = $urandom();
            end
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
